bomb_scheduler: RTL and testbench

- Owns up to NUM_BOMBS live bombs placed by the player.
- Counts each bomb's fuse in OneSecPulse ticks.
- Arbitrates the single shared blast unit: issues a one-cycle blast request carrying the bomb's top-left coordinates, then waits for that unit's explode output to rise and fall before firing the next.
- Sits between player/keyboard logic and the blast unit in the bomb subsystem.

---
 rtl/bomb_pkg.sv | 29 ++
 rtl/bomb_slot.sv | 55 +++++
 rtl/bomb_scheduler.sv | 175 +++++++++++++++++
 tb/tb_bomb_scheduler.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bomb_pkg.sv
`default_nettype none
// ============================================================================
// Module : bomb_pkg
// Brief  : Shared arbiter state type, coordinate width and screen constants.
// Rev    : 1.0  initial release
// ============================================================================
package bomb_pkg;

  localparam int COORD_W     = 11;
  localparam int OFFSCREEN_X = 640;
  localparam int OFFSCREEN_Y = 480;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_ON  = 2'd1,
    S_WAIT_OFF = 2'd2
  } arb_state_t;

  // True when two coordinates on one axis are no further apart than lim.
  function automatic logic coord_near(input logic [COORD_W-1:0] a,
                                      input logic [COORD_W-1:0] b,
                                      input logic [COORD_W-1:0] lim);
    logic [COORD_W-1:0] d;
    d = (a >= b) ? (a - b) : (b - a);
    return (d <= lim);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bomb_slot.sv
`default_nettype none
// ============================================================================
// Module : bomb_slot
// Brief  : One bomb slot: live flag, latched position, fuse countdown, expiry.
// Rev    : 1.0  initial release
// ============================================================================
module bomb_slot
  import bomb_pkg::*;
#(
  parameter int FUSE_SEC = 3
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               tick,
  input  logic               load,
  input  logic               clear,
  input  logic               force_zero,
  input  logic [COORD_W-1:0] load_x,
  input  logic [COORD_W-1:0] load_y,
  output logic               valid,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               expired
);

  localparam int c_FUSE_W = $clog2(FUSE_SEC + 1);

  logic [c_FUSE_W-1:0] r_fuse;

  // A freshly loaded bomb ignores a tick arriving in its load cycle.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      valid  <= 1'b0;
      x      <= '0;
      y      <= '0;
      r_fuse <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid  <= 1'b1;
      x      <= load_x;
      y      <= load_y;
      r_fuse <= c_FUSE_W'(FUSE_SEC);
    end else if (valid) begin
      if (force_zero)
        r_fuse <= '0;
      else if (tick && (r_fuse != '0))
        r_fuse <= r_fuse - c_FUSE_W'(1);
    end
  end

  assign expired = valid && (r_fuse == '0);

endmodule
`default_nettype wire

// File: rtl/bomb_scheduler.sv
`default_nettype none
// ============================================================================
// Module : bomb_scheduler
// Brief  : Bomb slot pool with fuse timing and blast-unit arbitration.
//          Define CHAIN_REACTION_EN to zero the fuses of nearby row/column
//          bombs whenever a blast is issued.
// Rev    : 1.0  initial release
// ============================================================================
module bomb_scheduler
  import bomb_pkg::*;
#(
  parameter int NUM_BOMBS = 4,
  parameter int FUSE_SEC  = 3,
  parameter int TILE      = 32
) (
  input  logic                         clk,
  input  logic                         resetN,
  input  logic                         OneSecPulse,
  input  logic                         place_req,
  input  logic [COORD_W-1:0]           place_X,
  input  logic [COORD_W-1:0]           place_Y,
  output logic                         place_ack,
  output logic                         place_nack,
  input  logic                         explode,
  output logic                         blast,
  output logic [COORD_W-1:0]           bomb_topLeftX,
  output logic [COORD_W-1:0]           bomb_topLeftY,
  output logic [NUM_BOMBS-1:0]         slot_valid,
  output logic [NUM_BOMBS*COORD_W-1:0] slot_X,
  output logic [NUM_BOMBS*COORD_W-1:0] slot_Y,
  output logic                         busy
);

  localparam int                 c_IDX_W      = (NUM_BOMBS > 1) ? $clog2(NUM_BOMBS) : 1;
  localparam logic [COORD_W-1:0] c_CHAIN_DIST = COORD_W'(2 * TILE);
`ifdef CHAIN_REACTION_EN
  localparam logic               c_CHAIN_EN   = 1'b1;
`else
  localparam logic               c_CHAIN_EN   = 1'b0;
`endif

  arb_state_t           r_state;
  logic [1:0]           r_to;
  logic                 r_req_d;

  logic [NUM_BOMBS-1:0] w_valid, w_expired, w_load, w_clear, w_force;
  logic [COORD_W-1:0]   w_x [NUM_BOMBS];
  logic [COORD_W-1:0]   w_y [NUM_BOMBS];
  logic                 w_dup, w_has_free, w_has_exp;
  logic [c_IDX_W-1:0]   w_free_idx, w_exp_idx;
  logic [COORD_W-1:0]   w_fire_x, w_fire_y;
  logic                 w_place_edge, w_do_place, w_fire;

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    w_dup      = 1'b0;
    w_has_free = 1'b0;
    w_free_idx = '0;
    w_has_exp  = 1'b0;
    w_exp_idx  = '0;
    w_fire_x   = '0;
    w_fire_y   = '0;
    for (int i = NUM_BOMBS - 1; i >= 0; i--) begin
      if (w_valid[i] && (w_x[i] == place_X) && (w_y[i] == place_Y))
        w_dup = 1'b1;
      if (!w_valid[i]) begin
        w_has_free = 1'b1;
        w_free_idx = c_IDX_W'(i);
      end
      if (w_expired[i]) begin
        w_has_exp = 1'b1;
        w_exp_idx = c_IDX_W'(i);
        w_fire_x  = w_x[i];
        w_fire_y  = w_y[i];
      end
    end
  end

  assign w_place_edge = place_req && !r_req_d;
  assign w_do_place   = w_place_edge && !w_dup && w_has_free;
  assign w_fire       = (r_state == S_IDLE) && w_has_exp;
  assign slot_valid   = w_valid;

  generate
    for (genvar i = 0; i < NUM_BOMBS; i++) begin : g_slot
      assign w_load[i]  = w_do_place && (w_free_idx == c_IDX_W'(i));
      assign w_clear[i] = w_fire && (w_exp_idx == c_IDX_W'(i));
      assign w_force[i] = c_CHAIN_EN && w_fire && w_valid[i] && !w_clear[i] &&
                          (((w_y[i] == w_fire_y) && coord_near(w_x[i], w_fire_x, c_CHAIN_DIST)) ||
                           ((w_x[i] == w_fire_x) && coord_near(w_y[i], w_fire_y, c_CHAIN_DIST)));

      bomb_slot #(
        .FUSE_SEC (FUSE_SEC)
      ) u_slot (
        .clk        (clk),
        .resetN     (resetN),
        .tick       (OneSecPulse),
        .load       (w_load[i]),
        .clear      (w_clear[i]),
        .force_zero (w_force[i]),
        .load_x     (place_X),
        .load_y     (place_Y),
        .valid      (w_valid[i]),
        .x          (w_x[i]),
        .y          (w_y[i]),
        .expired    (w_expired[i])
      );

      assign slot_X[i*COORD_W +: COORD_W] = w_x[i];
      assign slot_Y[i*COORD_W +: COORD_W] = w_y[i];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!resetN) begin
      r_req_d    <= 1'b0;
      place_ack  <= 1'b0;
      place_nack <= 1'b0;
    end else begin
      r_req_d    <= place_req;
      place_ack  <= w_do_place;
      place_nack <= w_place_edge && !w_do_place;
    end
  end

  // Arbiter: one blast in flight; waits for the blast unit's explode pulse.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      r_state       <= S_IDLE;
      r_to          <= 2'd0;
      blast         <= 1'b0;
      busy          <= 1'b0;
      bomb_topLeftX <= '0;
      bomb_topLeftY <= '0;
    end else begin
      blast <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_fire) begin
            blast         <= 1'b1;
            busy          <= 1'b1;
            bomb_topLeftX <= w_fire_x;
            bomb_topLeftY <= w_fire_y;
            r_to          <= 2'd0;
            r_state       <= S_WAIT_ON;
          end
        end
        S_WAIT_ON: begin
          if (explode) begin
            r_state <= S_WAIT_OFF;
          end else if (OneSecPulse) begin
            if (r_to == 2'd3) begin
              r_state <= S_IDLE;
              busy    <= 1'b0;
            end else begin
              r_to <= r_to + 2'd1;
            end
          end
        end
        S_WAIT_OFF: begin
          if (!explode) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bomb_scheduler.sv
`default_nettype none
// ============================================================================
// Module : tb_bomb_scheduler
// Brief  : Directed and randomized bench for bomb_scheduler with a slot-level
//          reference model checked every cycle.
// Rev    : 1.0  initial release
// ============================================================================
module tb_bomb_scheduler;

  localparam int NB = 4;
  localparam int FS = 3;
  localparam int TL = 32;
  localparam int CW = 11;
`ifdef CHAIN_REACTION_EN
  localparam int c_CHAIN_BLASTS = 2;
`else
  localparam int c_CHAIN_BLASTS = 1;
`endif

  logic             clk = 1'b0;
  logic             resetN, OneSecPulse, place_req, explode;
  logic [CW-1:0]    place_X, place_Y;
  logic             place_ack, place_nack, blast, busy;
  logic [CW-1:0]    bomb_topLeftX, bomb_topLeftY;
  logic [NB-1:0]    slot_valid;
  logic [NB*CW-1:0] slot_X, slot_Y;

  int  n_checks = 0;
  int  n_errors = 0;
  int  blast_cnt = 0;
  bit  resp_en = 1'b1;

  bomb_scheduler #(.NUM_BOMBS(NB), .FUSE_SEC(FS), .TILE(TL)) dut (
    .clk           (clk),
    .resetN        (resetN),
    .OneSecPulse   (OneSecPulse),
    .place_req     (place_req),
    .place_X       (place_X),
    .place_Y       (place_Y),
    .place_ack     (place_ack),
    .place_nack    (place_nack),
    .explode       (explode),
    .blast         (blast),
    .bomb_topLeftX (bomb_topLeftX),
    .bomb_topLeftY (bomb_topLeftY),
    .slot_valid    (slot_valid),
    .slot_X        (slot_X),
    .slot_Y        (slot_Y),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit m_init = 1'b0;
  bit m_v [NB];
  int m_x [NB], m_y [NB], m_f [NB];
  int m_mode, m_to;            // mode: 0 idle, 1 waiting for explode, 2 waiting for it to drop
  bit m_reqd;
  bit e_ack, e_nack, e_blast, e_busy;
  int e_bx, e_by;

  function automatic int iabs(input int a);
    return (a < 0) ? -a : a;
  endfunction

  task automatic model_step(input logic rn, input logic tk, input logic rq,
                            input int px, input int py, input logic ex);
    int  fire, freek;
    bit  dup, edge_r;
    if (!rn) begin
      for (int i = 0; i < NB; i++) begin m_v[i] = 0; m_x[i] = 0; m_y[i] = 0; m_f[i] = 0; end
      m_mode = 0; m_to = 0; m_reqd = 0;
      e_ack = 0; e_nack = 0; e_blast = 0; e_busy = 0; e_bx = 0; e_by = 0;
      m_init = 1;
      return;
    end
    fire = -1;
    if (m_mode == 0)
      for (int i = 0; i < NB; i++) if (fire < 0 && m_v[i] && m_f[i] == 0) fire = i;
    dup = 0; freek = -1;
    for (int i = 0; i < NB; i++) begin
      if (m_v[i] && m_x[i] == px && m_y[i] == py) dup = 1;
      if (freek < 0 && !m_v[i]) freek = i;
    end
    edge_r = rq && !m_reqd;
    e_ack  = edge_r && !dup && (freek >= 0);
    e_nack = edge_r && !e_ack;
    if (tk) for (int i = 0; i < NB; i++) if (m_v[i] && m_f[i] > 0) m_f[i]--;
    e_blast = 0;
    if (fire >= 0) begin
`ifdef CHAIN_REACTION_EN
      for (int i = 0; i < NB; i++)
        if (i != fire && m_v[i] &&
            ((m_y[i] == m_y[fire] && iabs(m_x[i] - m_x[fire]) <= 2*TL) ||
             (m_x[i] == m_x[fire] && iabs(m_y[i] - m_y[fire]) <= 2*TL)))
          m_f[i] = 0;
`endif
      m_v[fire] = 0;
      e_blast = 1; e_bx = m_x[fire]; e_by = m_y[fire];
      m_mode = 1; m_to = 0;
    end else if (m_mode == 1) begin
      if (ex) m_mode = 2;
      else if (tk) begin
        if (m_to == 3) m_mode = 0; else m_to++;
      end
    end else if (m_mode == 2) begin
      if (!ex) m_mode = 0;
    end
    if (e_ack) begin
      m_v[freek] = 1; m_x[freek] = px; m_y[freek] = py; m_f[freek] = FS;
    end
    e_busy = (m_mode != 0);
    m_reqd = rq;
  endtask

  // Per-cycle comparison against the model.
  initial begin
    logic [NB-1:0] ev;
    forever begin
      @(posedge clk);
      model_step(resetN, OneSecPulse, place_req, int'(place_X), int'(place_Y), explode);
      #1;
      if (blast === 1'b1) blast_cnt++;
      if (m_init) begin
        for (int i = 0; i < NB; i++) ev[i] = m_v[i];
        chk("ack",   place_ack,     e_ack);
        chk("nack",  place_nack,    e_nack);
        chk("blast", blast,         e_blast);
        chk("busy",  busy,          e_busy);
        chk("bx",    bomb_topLeftX, e_bx);
        chk("by",    bomb_topLeftY, e_by);
        chk("valid", slot_valid,    ev);
        for (int i = 0; i < NB; i++)
          if (m_v[i]) begin
            chk("slot_x", slot_X[i*CW +: CW], m_x[i]);
            chk("slot_y", slot_Y[i*CW +: CW], m_y[i]);
          end
      end
    end
  end

  // Blast unit stand-in: explode rises after a short delay and drops later.
  initial begin
    explode = 1'b0;
    forever begin
      @(negedge clk);
      if (blast === 1'b1 && resp_en) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        explode = 1'b1;
        repeat ($urandom_range(1, 4)) @(negedge clk);
        explode = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk); OneSecPulse = 1'b1;
    @(negedge clk); OneSecPulse = 1'b0;
  endtask

  task automatic place_lit(input string nm, input int x, input int y, input bit exp_ack);
    @(negedge clk);
    place_req = 1'b1; place_X = CW'(x); place_Y = CW'(y);
    @(posedge clk); #2;
    chk(nm, {place_ack, place_nack}, exp_ack ? 2'b10 : 2'b01);
    @(negedge clk); place_req = 1'b0;
  endtask

  task automatic wait_blast(input string nm, input int max_cyc);
    bit seen = 1'b0;
    for (int k = 0; k < max_cyc && !seen; k++) begin
      @(posedge clk); #2;
      if (blast === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (!seen) begin
      n_errors++;
      $display("FAIL %s: got no blast within %0d cycles, expected one", nm, max_cyc);
    end
  endtask

  task automatic wait_idle(input string nm, input int max_cyc);
    bit seen = 1'b0;
    for (int k = 0; k < max_cyc && !seen; k++) begin
      @(posedge clk); #2;
      if (busy === 1'b0 && explode === 1'b0) seen = 1'b1;
    end
    n_checks++;
    if (!seen) begin
      n_errors++;
      $display("FAIL %s: got busy after %0d cycles, expected idle", nm, max_cyc);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int cnt, k, b0;
    resetN = 1'b0; OneSecPulse = 1'b0;
    place_req = 1'b1; place_X = 11'd96; place_Y = 11'd64;

    // Reset with a request held: nothing must be accepted.
    repeat (2) @(negedge clk);
    chk("rst_valid", slot_valid, 4'b0000);
    chk("rst_ack",   place_ack,  1'b0);
    chk("rst_blast", blast,      1'b0);
    chk("rst_busy",  busy,       1'b0);
    place_req = 1'b0; resetN = 1'b1;

    @(negedge clk);
    place_req = 1'b1; place_X = 11'd96; place_Y = 11'd64;
    @(posedge clk); #2;
    chk("first_ack",   place_ack,  1'b1);
    chk("first_valid", slot_valid, 4'b0001);
    @(negedge clk); place_req = 1'b0;

    // Fuse: three ticks then exactly one blast at the bomb position.
    repeat (3) tick();
    wait_blast("fuse_blast", 5);
    chk("fuse_x",     bomb_topLeftX, 11'd96);
    chk("fuse_y",     bomb_topLeftY, 11'd64);
    chk("fuse_valid", slot_valid,    4'b0000);
    wait_idle("fuse_idle", 50);

    // Duplicate while live, then fill up and overflow.
    place_lit("pl0",  96, 64, 1'b1);
    place_lit("pl1",   0,  0, 1'b1);
    place_lit("pl2",  32,  0, 1'b1);
    place_lit("dup",  96, 64, 1'b0);
    place_lit("pl3",  64,  0, 1'b1);
    place_lit("full", 128, 0, 1'b0);
    chk("full_valid", slot_valid, 4'b1111);

    // All four expire on one tick: fired in ascending slot order.
    repeat (3) tick();
    wait_blast("arb_b0", 5);
    chk("arb0_x", bomb_topLeftX, 11'd96);
    chk("arb0_y", bomb_topLeftY, 11'd64);
    k = 0;
    while (explode !== 1'b1 && k < 50)  begin @(posedge clk); #2; k++; end
    while (explode !== 1'b0 && k < 100) begin @(posedge clk); #2; k++; end
    cnt = 0;
    while (blast !== 1'b1 && cnt < 20) begin @(posedge clk); #2; cnt++; end
    chk("arb_gap_le3", (cnt >= 1 && cnt <= 3), 1'b1);
    chk("arb1_x", bomb_topLeftX, 11'd0);
    wait_blast("arb_b2", 40);
    chk("arb2_x", bomb_topLeftX, 11'd32);
    wait_blast("arb_b3", 40);
    chk("arb3_x", bomb_topLeftX, 11'd64);
    wait_idle("arb_idle", 50);

    // Timeout: no explode, the next bomb waits for the fourth tick.
    resp_en = 1'b0;
    place_lit("to_a",   0, 128, 1'b1);
    place_lit("to_b", 320, 256, 1'b1);
    repeat (3) tick();
    wait_blast("to_first", 5);
    chk("to_first_x", bomb_topLeftX, 11'd0);
    b0 = blast_cnt;
    repeat (3) tick();
    repeat (10) @(negedge clk);
    chk("to_hold", blast_cnt - b0, 0);
    tick();
    wait_blast("to_second", 5);
    chk("to_second_x", bomb_topLeftX, 11'd320);
    repeat (4) tick();
    resp_en = 1'b1;
    wait_idle("to_idle", 50);

    // Second bomb placed on the tick that expires the first one.
    place_lit("ch_a", 96, 64, 1'b1);
    tick(); tick();
    @(negedge clk);
    OneSecPulse = 1'b1; place_req = 1'b1; place_X = 11'd160; place_Y = 11'd64;
    @(negedge clk);
    OneSecPulse = 1'b0; place_req = 1'b0;
    b0 = blast_cnt;
    repeat (40) @(negedge clk);
    chk("chain_early", blast_cnt - b0, c_CHAIN_BLASTS);
    repeat (3) tick();
    repeat (30) @(negedge clk);
    chk("chain_total", blast_cnt - b0, 2);
    chk("chain_x", bomb_topLeftX, 11'd160);

    // Randomized traffic, including resets and a silent blast unit.
    for (int c = 0; c < 2500; c++) begin
      @(negedge clk);
      resetN      = ($urandom_range(0, 399) != 0);
      OneSecPulse = ($urandom_range(0, 7) == 0);
      if (place_req) place_req = ($urandom_range(0, 2) == 0);
      else           place_req = ($urandom_range(0, 4) == 0);
      place_X = CW'(32 * $urandom_range(0, 5));
      place_Y = CW'(64 * $urandom_range(0, 2));
      if ((c % 300) == 299) resp_en = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    resetN = 1'b1; place_req = 1'b0; OneSecPulse = 1'b0;
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
